// File: rtl/dcache_writeback_buffer_pkg.sv
// Shared types and constants for the multi-entry dcache writeback buffer.
// Widths mirror the ariane/riscv configuration used by the writeback dcache.
package dcache_writeback_buffer_pkg;

  localparam int unsigned PLEN                           = 34;
  localparam int unsigned XLEN                           = 32;
  localparam int unsigned DCACHE_LINE_WIDTH              = 128;
  localparam int unsigned DCACHE_OFFSET_WIDTH            = $clog2(DCACHE_LINE_WIDTH / 8);
  localparam int unsigned NUMBER_OF_WORDS_IN_CACHE_BLOCK = DCACHE_LINE_WIDTH / XLEN;
  localparam int unsigned WB_WORDS_PER_LINE              = NUMBER_OF_WORDS_IN_CACHE_BLOCK;

  localparam logic [2:0] MEMORY_REQUEST_SIZE_FOUR_BYTES = 3'b010;
  localparam logic [2:0] MEMORY_REQUEST_SIZE_CACHEBLOCK = 3'b111;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_REQ,
    WB_WAIT_ACK
  } wb_state_t;

  typedef struct packed {
    logic                         valid;
    logic [PLEN-1:0]              address;
    logic [DCACHE_LINE_WIDTH-1:0] data;
  } wb_entry_t;

  // Align a CPU address to the granule of the given memory request size.
  function automatic logic [PLEN-1:0] cpu_to_memory_address(input logic [PLEN-1:0] addr,
                                                             input logic [2:0]      size);
    logic [PLEN-1:0] w_addr;
    w_addr = addr;
    case (size)
      MEMORY_REQUEST_SIZE_FOUR_BYTES: w_addr[1:0] = 2'b00;
      MEMORY_REQUEST_SIZE_CACHEBLOCK: w_addr[DCACHE_OFFSET_WIDTH-1:0] = '0;
      default: ;
    endcase
    return w_addr;
  endfunction

endpackage

// File: rtl/dcache_writeback_buffer.sv
// FIFO of evicted dirty lines drained word by word to memory, with a
// combinational youngest-first line lookup for load forwarding.
module dcache_writeback_buffer
  import dcache_writeback_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned LINE_WIDTH = DCACHE_LINE_WIDTH,
  parameter int unsigned WORD_WIDTH = XLEN,
  parameter int unsigned ADDR_WIDTH = PLEN
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_valid_i,
  output logic                         push_ready_o,
  input  logic [ADDR_WIDTH-1:0]        push_addr_i,
  input  logic [LINE_WIDTH-1:0]        push_data_i,
  input  logic [ADDR_WIDTH-1:0]        lookup_addr_i,
  output logic                         lookup_hit_o,
  output logic [LINE_WIDTH-1:0]        lookup_data_o,
  output logic                         mem_req_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_ack_i,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  output logic [WORD_WIDTH-1:0]        mem_wdata_o,
  output logic [2:0]                   mem_size_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned CW         = $clog2(DEPTH + 1);
  localparam int unsigned PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IW         = $clog2(WB_WORDS_PER_LINE);
  localparam int unsigned WORD_BYTES = WORD_WIDTH / 8;

  wb_entry_t                    r_entries [DEPTH];
  logic [PW-1:0]                r_head;
  logic [PW-1:0]                r_tail;
  logic [CW-1:0]                r_count;
  logic                         r_empty;
  logic                         r_push_ready;
  wb_state_t                    r_state;
  logic [IW-1:0]                r_idx;
  logic                         r_mem_req;
  logic [ADDR_WIDTH-1:0]        r_mem_addr;
  logic [WORD_WIDTH-1:0]        r_mem_wdata;

  wb_state_t                    w_state_d;
  logic [IW-1:0]                w_idx_d;
  logic                         w_push;
  logic                         w_pop;
  logic [CW-1:0]                w_count_d;
  logic                         w_mem_req_d;
  logic [ADDR_WIDTH-1:0]        w_mem_addr_d;
  logic [WORD_WIDTH-1:0]        w_mem_wdata_d;
  logic [PLEN-1:0]              w_lookup_line;
  logic                         w_lookup_hit;
  logic [DCACHE_LINE_WIDTH-1:0] w_lookup_data;

  // Pointers wrap modulo DEPTH, which also covers the single-entry case.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign w_push = push_valid_i && r_push_ready;

  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_d = r_count - CW'(1);
    end
  end

  // Line storage and occupancy; ready is registered so it never sees the pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_empty      <= 1'b1;
      r_push_ready <= 1'b1;
    end else begin
      if (w_push) begin
        r_entries[r_tail] <= '{valid:   1'b1,
                               address: cpu_to_memory_address(PLEN'(push_addr_i),
                                                              MEMORY_REQUEST_SIZE_CACHEBLOCK),
                               data:    DCACHE_LINE_WIDTH'(push_data_i)};
        r_tail <= ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_entries[r_head].valid <= 1'b0;
        r_head                  <= ptr_inc(r_head);
      end
      r_count      <= w_count_d;
      r_empty      <= (w_count_d == '0);
      r_push_ready <= (w_count_d < CW'(DEPTH));
    end
  end

  // Walk oldest to youngest so the last match (youngest copy) wins.
  assign w_lookup_line = cpu_to_memory_address(PLEN'(lookup_addr_i), MEMORY_REQUEST_SIZE_CACHEBLOCK);

  always_comb begin
    w_lookup_hit  = 1'b0;
    w_lookup_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_entries[PW'((32'(r_head) + i) % DEPTH)].valid &&
          (r_entries[PW'((32'(r_head) + i) % DEPTH)].address == w_lookup_line)) begin
        w_lookup_hit  = 1'b1;
        w_lookup_data = r_entries[PW'((32'(r_head) + i) % DEPTH)].data;
      end
    end
  end

  // Drain FSM next state; memory outputs are computed for the next state and registered.
  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_pop     = 1'b0;
    case (r_state)
      WB_IDLE: begin
        if (!r_empty) begin
          w_state_d = WB_REQ;
          w_idx_d   = '0;
        end
      end
      WB_REQ: begin
        if (mem_gnt_i) begin
          w_state_d = WB_WAIT_ACK;
        end
      end
      WB_WAIT_ACK: begin
        if (mem_ack_i) begin
          if (r_idx == IW'(WB_WORDS_PER_LINE - 1)) begin
            w_pop     = 1'b1;
            w_idx_d   = '0;
            w_state_d = WB_IDLE;
          end else begin
            w_idx_d   = r_idx + IW'(1);
            w_state_d = WB_REQ;
          end
        end
      end
      default: w_state_d = WB_IDLE;
    endcase

    w_mem_req_d   = (w_state_d == WB_REQ);
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    if (w_mem_req_d) begin
      w_mem_addr_d  = ADDR_WIDTH'(r_entries[r_head].address) +
                      ADDR_WIDTH'(w_idx_d) * ADDR_WIDTH'(WORD_BYTES);
      w_mem_wdata_d = r_entries[r_head].data[32'(w_idx_d) * WORD_WIDTH +: WORD_WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= WB_IDLE;
      r_idx       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_d;
      r_idx       <= w_idx_d;
      r_mem_req   <= w_mem_req_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
    end
  end

  assign push_ready_o  = r_push_ready;
  assign lookup_hit_o  = w_lookup_hit;
  assign lookup_data_o = LINE_WIDTH'(w_lookup_data);
  assign mem_req_o     = r_mem_req;
  assign mem_addr_o    = r_mem_addr;
  assign mem_wdata_o   = r_mem_wdata;
  assign mem_size_o    = MEMORY_REQUEST_SIZE_FOUR_BYTES;
  assign empty_o       = r_empty;
  assign count_o       = r_count;

endmodule

// File: tb/tb_dcache_writeback_buffer.sv
// Directed bench for dcache_writeback_buffer: drain order, back-pressure,
// lookup forwarding, duplicates, grant stalls and reset mid-drain.
module tb_dcache_writeback_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         push_valid;
  logic         push_ready;
  logic [33:0]  push_addr;
  logic [127:0] push_data;
  logic [33:0]  lookup_addr;
  logic         lookup_hit;
  logic [127:0] lookup_data;
  logic         mem_req;
  logic         mem_gnt;
  logic         mem_ack;
  logic [33:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [2:0]   mem_size;
  logic         empty;
  logic [1:0]   count;

  int n_tests = 0;
  int n_fail  = 0;

  dcache_writeback_buffer #(.DEPTH(2)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .push_valid_i  (push_valid),
    .push_ready_o  (push_ready),
    .push_addr_i   (push_addr),
    .push_data_i   (push_data),
    .lookup_addr_i (lookup_addr),
    .lookup_hit_o  (lookup_hit),
    .lookup_data_o (lookup_data),
    .mem_req_o     (mem_req),
    .mem_gnt_i     (mem_gnt),
    .mem_ack_i     (mem_ack),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_size_o    (mem_size),
    .empty_o       (empty),
    .count_o       (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_push(input logic [33:0] a, input logic [127:0] d);
    push_valid = 1'b1;
    push_addr  = a;
    push_data  = d;
    @(negedge clk);
    push_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 50 && mem_req !== 1'b1; i++) @(negedge clk);
    check({tag, "_req"}, 128'(mem_req), 128'(1'b1));
  endtask

  // One memory beat: optional grant stall, grant, then ack one cycle later.
  task automatic drain_word(input string tag, input logic [33:0] a, input logic [31:0] d,
                            input int stall);
    wait_req(tag);
    check({tag, "_addr"}, 128'(mem_addr), 128'(a));
    check({tag, "_data"}, 128'(mem_wdata), 128'(d));
    check({tag, "_size"}, 128'(mem_size), 128'(3'b010));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, "_stall_req"},  128'(mem_req),   128'(1'b1));
      check({tag, "_stall_addr"}, 128'(mem_addr),  128'(a));
      check({tag, "_stall_data"}, 128'(mem_wdata), 128'(d));
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check({tag, "_req_drop"}, 128'(mem_req), 128'(1'b0));
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic drain_line(input string tag, input logic [33:0] a, input logic [127:0] d,
                            input int stall_word, input int stall);
    for (int w = 0; w < 4; w++) begin
      drain_word(tag, a + 34'(w * 4), d[w*32 +: 32], (w == stall_word) ? stall : 0);
    end
  endtask

  initial begin
    logic [127:0] d_x;
    logic [127:0] d_y;
    logic         seen_req;

    rst_n       = 1'b0;
    push_valid  = 1'b0;
    push_addr   = '0;
    push_data   = '0;
    lookup_addr = '0;
    mem_gnt     = 1'b0;
    mem_ack     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_count", 128'(count), 128'(0));
    check("rst_empty", 128'(empty), 128'(1));
    check("rst_ready", 128'(push_ready), 128'(1));
    check("rst_req",   128'(mem_req), 128'(0));
    check("rst_addr",  128'(mem_addr), 128'(0));
    check("rst_wdata", 128'(mem_wdata), 128'(0));
    check("rst_hit",   128'(lookup_hit), 128'(0));
    check("rst_ldata", lookup_data, 128'(0));

    // Single drain with offset-bearing push address
    do_push(34'h0_8000_0014, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    check("t1_count", 128'(count), 128'(1));
    check("t1_empty", 128'(empty), 128'(0));
    drain_word("t1_w0", 34'h0_8000_0010, 32'hAAAAAAAA, 0);
    drain_word("t1_w1", 34'h0_8000_0014, 32'hBBBBBBBB, 0);
    drain_word("t1_w2", 34'h0_8000_0018, 32'hCCCCCCCC, 0);
    drain_word("t1_w3", 34'h0_8000_001C, 32'hDDDDDDDD, 0);
    check("t1_empty_end", 128'(empty), 128'(1));
    check("t1_count_end", 128'(count), 128'(0));

    // Full back-pressure and FIFO order
    d_x = 128'h11110003_11110002_11110001_11110000;
    d_y = 128'h22220003_22220002_22220001_22220000;
    do_push(34'h1000, d_x);
    do_push(34'h2000, d_y);
    check("t2_ready_full", 128'(push_ready), 128'(0));
    check("t2_count_full", 128'(count), 128'(2));
    do_push(34'h3000, 128'h3333);
    check("t2_count_refused", 128'(count), 128'(2));
    lookup_addr = 34'h3000;
    #1;
    check("t2_refused_hit", 128'(lookup_hit), 128'(0));
    drain_line("t2_l0", 34'h1000, d_x, -1, 0);
    check("t2_count_mid", 128'(count), 128'(1));
    check("t2_ready_mid", 128'(push_ready), 128'(1));
    drain_line("t2_l1", 34'h2000, d_y, -1, 0);
    check("t2_empty_end", 128'(empty), 128'(1));

    // Lookup forwarding
    d_x = 128'h44440003_44440002_44440001_44440000;
    do_push(34'h4000, d_x);
    lookup_addr = 34'h400C;
    #1;
    check("t3_hit",  128'(lookup_hit), 128'(1));
    check("t3_data", lookup_data, d_x);
    lookup_addr = 34'h4010;
    #1;
    check("t3_miss_next_line", 128'(lookup_hit), 128'(0));
    lookup_addr = 34'h400C;
    drain_line("t3_l0", 34'h4000, d_x, -1, 0);
    #1;
    check("t3_miss_after_pop", 128'(lookup_hit), 128'(0));

    // Duplicate line address: lookup sees youngest, memory sees both in order
    d_x = 128'h55550003_55550002_55550001_55550000;
    d_y = 128'h66660003_66660002_66660001_66660000;
    do_push(34'h5000, d_x);
    do_push(34'h5000, d_y);
    lookup_addr = 34'h5008;
    #1;
    check("t4_hit",  128'(lookup_hit), 128'(1));
    check("t4_data", lookup_data, d_y);
    drain_line("t4_x", 34'h5000, d_x, -1, 0);
    drain_line("t4_y", 34'h5000, d_y, -1, 0);
    check("t4_empty_end", 128'(empty), 128'(1));

    // Grant stall on word 2
    d_x = 128'h77770003_77770002_77770001_77770000;
    do_push(34'h6000, d_x);
    drain_line("t5", 34'h6000, d_x, 2, 5);
    check("t5_empty_end", 128'(empty), 128'(1));

    // Reset while waiting for the ack of word 1, then a late ack
    d_x = 128'h88880003_88880002_88880001_88880000;
    do_push(34'h7000, d_x);
    drain_word("t6_w0", 34'h7000, 32'h88880000, 0);
    wait_req("t6_w1");
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("t6_rst_req",   128'(mem_req), 128'(0));
    check("t6_rst_count", 128'(count), 128'(0));
    check("t6_rst_empty", 128'(empty), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack  = 1'b0;
    seen_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen_req |= mem_req;
      @(negedge clk);
    end
    lookup_addr = 34'h7000;
    #1;
    check("t6_no_req",  128'(seen_req), 128'(0));
    check("t6_count",   128'(count), 128'(0));
    check("t6_empty",   128'(empty), 128'(1));
    check("t6_ready",   128'(push_ready), 128'(1));
    check("t6_addr",    128'(mem_addr), 128'(0));
    check("t6_wdata",   128'(mem_wdata), 128'(0));
    check("t6_hit",     128'(lookup_hit), 128'(0));
    check("t6_ldata",   lookup_data, 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_writeback_buffer.md
Name: dcache_writeback_buffer

Overview:
- Multi-entry writeback buffer for the writeback dcache. It is the parametrised successor of the single-entry writeback record.
- Accepts evicted dirty cache lines from the dcache controller and queues them in FIFO order.
- Drains each line to main memory one word at a time, using word-sized writes with a req/gnt then ack handshake.
- Provides a combinational line-address lookup, so CPU loads can be served from a pending, not yet drained line.

Parameters:
- DEPTH, 2, number of line entries; power of two, 1..8.
- LINE_WIDTH, ariane_pkg::DCACHE_LINE_WIDTH (128), bits per cache line.
- WORD_WIDTH, riscv::XLEN (32), bits per memory write beat.
- ADDR_WIDTH, riscv::PLEN (34), physical address width.

Ports:
- clk_i  in  1  clock; the block has one clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- push_valid_i  in  1  controller offers an evicted line.
- push_ready_o  out  1  buffer can accept a line.
- push_addr_i  in  ADDR_WIDTH  line address; offset bits are ignored.
- push_data_i  in  LINE_WIDTH  line data.
- lookup_addr_i  in  ADDR_WIDTH  CPU physical address to probe.
- lookup_hit_o  out  1  a valid entry matches the line address.
- lookup_data_o  out  LINE_WIDTH  data of the youngest matching entry.
- mem_req_o  out  1  word write request.
- mem_gnt_i  in  1  memory accepted the request.
- mem_ack_i  in  1  memory completed the write.
- mem_addr_o  out  ADDR_WIDTH  word-aligned write address.
- mem_wdata_o  out  WORD_WIDTH  write data.
- mem_size_o  out  3  constant MEMORY_REQUEST_SIZE_FOUR_BYTES (3'b010).
- empty_o  out  1  no valid entries.
- count_o  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Reset values:
  - all entries invalid; head/tail pointers 0; count_o=0; empty_o=1; push_ready_o=1;
  - mem_req_o=0; mem_addr_o=0; mem_wdata_o=0; lookup_hit_o=0; lookup_data_o=0;
  - drain FSM in WB_IDLE; word index 0.
- Push:
  - Accepted when push_valid_i && push_ready_o, where push_ready_o = (count < DEPTH).
  - The stored address has offset bits [DCACHE_OFFSET_WIDTH-1:0] cleared.
  - count_o and empty_o update the next cycle.
  - A push while full is not accepted and the buffer is unchanged.
- Duplicate line addresses:
  - Pushing a line address already in the buffer is permitted.
  - Both copies drain in order.
  - Lookup returns the youngest copy.
- Lookup:
  - Purely combinational over valid entries; compares address bits above the offset.
  - Priority goes to the youngest entry (closest to tail).
  - An entry currently draining still matches until it is popped.
  - A line pushed in cycle N is visible to lookup from cycle N+1.
- Drain FSM, states WB_IDLE, WB_REQ, WB_WAIT_ACK:
  - WB_IDLE: if !empty, go to WB_REQ with word index 0.
  - WB_REQ: mem_req_o=1. mem_addr_o = head address + index*(WORD_WIDTH/8). mem_wdata_o = head data[index*WORD_WIDTH +: WORD_WIDTH]. Address and data are held stable until mem_gnt_i. On mem_gnt_i, go to WB_WAIT_ACK.
  - WB_WAIT_ACK: mem_req_o=0. On mem_ack_i:
    - if index == WORDS_PER_LINE-1: pop the head (invalidate, advance head pointer, index reset to 0), then go to WB_IDLE;
    - otherwise increment index and go to WB_REQ.
  - Only one word is outstanding at a time.
- Latency: push in cycle N gives mem_req_o no earlier than N+2 (the FSM sees !empty at N+1). The pop happens in the cycle after the last ack.
- Simultaneous push and pop in one cycle: both take effect and count is unchanged. A push while full is refused even if a pop occurs in the same cycle, because push_ready_o does not depend on the pop.
- Pointer wrap-around: pointers are modulo DEPTH.
- mem_ack_i or mem_gnt_i outside the expected state is ignored.
- Reset mid-drain: the buffer is emptied and the FSM returns to WB_IDLE. A late ack after reset is ignored.

Decomposition:
- Additions to dcache_pkg:
  - wb_state_t enum {WB_IDLE, WB_REQ, WB_WAIT_ACK};
  - wb_entry_t packed struct {valid, address[PLEN], data[LINE_WIDTH]}, generalising writeback_t;
  - WB_WORDS_PER_LINE = NUMBER_OF_WORDS_IN_CACHE_BLOCK.
- Reuse cpu_to_memory_address() for line alignment, with MEMORY_REQUEST_SIZE_CACHEBLOCK.
- No sub-module. Storage is a register array and the lookup priority encoder is inline.

Test Plan:
- Single drain: push addr 0x0_8000_0014 with data 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA; memory grants immediately and acks 1 cycle after the grant. Required: four writes 0x80000010/AAAAAAAA, 0x80000014/BBBBBBBB, 0x80000018/CCCCCCCC, 0x8000001C/DDDDDDDD, all with mem_size_o=3'b010; then empty_o=1 and count_o=0.
- Full back-pressure (DEPTH=2): push 0x1000 then 0x2000 with gnt held low. Required: push_ready_o=0 and count_o=2. A third push of 0x3000 is refused; raising gnt/ack drains 0x1000 before 0x2000.
- Lookup forwarding: with 0x4000 pending, probe 0x400C. Required: lookup_hit_o=1 with the stored data. Probing 0x4010 gives lookup_hit_o=0. After the pop of 0x4000, probing 0x400C gives hit=0.
- Duplicate address: push 0x5000 with data X, then 0x5000 with data Y. Required: lookup returns Y; memory sees all X words, then all Y words.
- Stall stability: hold gnt low for 5 cycles during word 2. Required: mem_req_o, mem_addr_o and mem_wdata_o stay unchanged across all 5 cycles.
- Reset mid-drain: assert rst_ni low after word 1 is granted, then pulse ack after release. Required: all outputs at reset values, no further mem_req_o, count_o=0.
